// File: rtl/gemm_operand_sequencer.sv
// gemm_operand_sequencer
//   Takes one decoded GEMM request and reads its operand matrices out of the
//   scratchpad one row at a time, in this order:
//     1. weights (rs2), only when new_weight is set
//     2. inputs (rs1)
//     3. partial sums (rs3)
//   Each row is handed to the systolic array tagged with its kind. When the
//   last partial-sum row has been consumed, rd is reported to writeback.
//
// Ports
//   CLK, nRST           clock, async active-low reset
//   gemm_*              request handshake and fields (rd/rs1/rs2/rs3/new_weight)
//   sp_ren/reg/row      scratchpad row-read request; accepted when sp_gnt
//   sp_rvalid/rdata     read data return (>=1 cycle after grant)
//   arr_valid/ready     row handshake to the systolic array
//   arr_kind/row/data   row tag (00 weight, 01 input, 10 psum), index, payload
//   done_valid/done_rd  one-cycle completion pulse with destination register
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | gemm_ready high, waiting for a request
// W      | streaming weight rows from rs2
// X      | streaming input rows from rs1
// P      | streaming partial-sum rows from rs3
// DONE   | done_valid pulse, back to IDLE next cycle
module gemm_operand_sequencer #(
  parameter  int DIM    = 4,
  parameter  int ELEM_W = 16,
  parameter  int REG_W  = 4,
  localparam int ROW_W  = DIM * ELEM_W,
  localparam int ROW_IW = $clog2(DIM)
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              gemm_valid,
  output logic              gemm_ready,
  input  logic [REG_W-1:0]  gemm_rd,
  input  logic [REG_W-1:0]  gemm_rs1,
  input  logic [REG_W-1:0]  gemm_rs2,
  input  logic [REG_W-1:0]  gemm_rs3,
  input  logic              gemm_new_weight,
  output logic              sp_ren,
  output logic [REG_W-1:0]  sp_reg,
  output logic [ROW_IW-1:0] sp_row,
  input  logic              sp_gnt,
  input  logic              sp_rvalid,
  input  logic [ROW_W-1:0]  sp_rdata,
  output logic              arr_valid,
  input  logic              arr_ready,
  output logic [1:0]        arr_kind,
  output logic [ROW_IW-1:0] arr_row,
  output logic [ROW_W-1:0]  arr_data,
  output logic              done_valid,
  output logic [REG_W-1:0]  done_rd
);

  typedef enum logic [2:0] {S_IDLE, S_W, S_X, S_P, S_DONE} state_e;

  state_e             state_q;
  logic [REG_W-1:0]   rd_q, rs1_q, rs2_q, rs3_q;
  logic [ROW_IW-1:0]  cnt_q;       // next row to request in this phase
  logic [ROW_IW-1:0]  out_row_q;   // row index of the read in flight
  logic               out_q;       // one read outstanding
  logic               issued_q;    // every row of this phase has been granted
  logic               ready_q;
  logic               arr_valid_q;
  logic [1:0]         arr_kind_q;
  logic [ROW_IW-1:0]  arr_row_q;
  logic [ROW_W-1:0]   arr_data_q;
  logic               done_q;
  logic [REG_W-1:0]   done_rd_q;

  logic               active;
  logic [REG_W-1:0]   phase_reg;
  logic [1:0]         phase_kind;
  logic               read_req;
  logic               grant;
  logic               capture;
  logic               last_drain;

  always_comb begin
    active     = 1'b1;
    phase_reg  = '0;
    phase_kind = 2'b00;
    case (state_q)
      S_W: begin phase_reg = rs2_q; phase_kind = 2'b00; end
      S_X: begin phase_reg = rs1_q; phase_kind = 2'b01; end
      S_P: begin phase_reg = rs3_q; phase_kind = 2'b10; end
      default: active = 1'b0;
    endcase
  end

  // The read request looks at arr_ready combinationally so the next grant can
  // land in the same cycle the previous row drains (one row every 2 cycles).
  assign read_req   = active & ~issued_q & ~out_q & (~arr_valid_q | arr_ready);
  assign grant      = read_req & sp_gnt;
  assign capture    = out_q & sp_rvalid;
  // Only the final row of a phase can sit in the buffer with issued_q set and
  // row index DIM-1, so this marks the end of the phase.
  assign last_drain = arr_valid_q & arr_ready & issued_q &
                      (arr_row_q == ROW_IW'(DIM - 1));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= S_IDLE;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rs3_q       <= '0;
      cnt_q       <= '0;
      out_row_q   <= '0;
      out_q       <= 1'b0;
      issued_q    <= 1'b0;
      ready_q     <= 1'b0;
      arr_valid_q <= 1'b0;
      arr_kind_q  <= 2'b00;
      arr_row_q   <= '0;
      arr_data_q  <= '0;
      done_q      <= 1'b0;
      done_rd_q   <= '0;
    end else begin
      done_q    <= 1'b0;
      done_rd_q <= '0;

      if (grant) begin
        out_q     <= 1'b1;
        out_row_q <= cnt_q;
        if (cnt_q == ROW_IW'(DIM - 1)) begin
          cnt_q    <= '0;
          issued_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + ROW_IW'(1);
        end
      end else if (capture) begin
        out_q <= 1'b0;
      end

      // A read is only granted with the buffer empty or draining, so a
      // capture never overwrites an unconsumed row.
      if (capture) begin
        arr_valid_q <= 1'b1;
        arr_kind_q  <= phase_kind;
        arr_row_q   <= out_row_q;
        arr_data_q  <= sp_rdata;
      end else if (arr_valid_q && arr_ready) begin
        arr_valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (ready_q && gemm_valid) begin
            rd_q     <= gemm_rd;
            rs1_q    <= gemm_rs1;
            rs2_q    <= gemm_rs2;
            rs3_q    <= gemm_rs3;
            cnt_q    <= '0;
            issued_q <= 1'b0;
            ready_q  <= 1'b0;
            state_q  <= gemm_new_weight ? S_W : S_X;
          end else begin
            ready_q <= 1'b1;
          end
        end
        S_W, S_X, S_P: begin
          if (last_drain) begin
            issued_q <= 1'b0;
            if (state_q == S_W) begin
              state_q <= S_X;
            end else if (state_q == S_X) begin
              state_q <= S_P;
            end else begin
              state_q   <= S_DONE;
              done_q    <= 1'b1;
              done_rd_q <= rd_q;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gemm_ready = ready_q;
  assign sp_ren     = read_req;
  assign sp_reg     = read_req ? phase_reg : '0;
  assign sp_row     = read_req ? cnt_q : '0;
  assign arr_valid  = arr_valid_q;
  assign arr_kind   = arr_kind_q;
  assign arr_row    = arr_row_q;
  assign arr_data   = arr_data_q;
  assign done_valid = done_q;
  assign done_rd    = done_rd_q;

endmodule
